// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - State encoding and address field layout shared by the cache controller and array
package cache_pkg;

    localparam int DEF_WORD_BITS        = 32;
    localparam int DEF_ADDR_BITS        = 32;
    localparam int DEF_TAG_BITS         = 22;
    localparam int DEF_WORD_BYTES_WIDTH = 2;
    localparam int DEF_LINE_WORDS_WIDTH = 2;
    localparam int DEF_LINE_INDEX_WIDTH = 6;

    // Byte address = {tag, index, word, byte}
    localparam int WORD_LSB  = DEF_WORD_BYTES_WIDTH;
    localparam int INDEX_LSB = DEF_WORD_BYTES_WIDTH + DEF_LINE_WORDS_WIDTH;
    localparam int TAG_LSB   = INDEX_LSB + DEF_LINE_INDEX_WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BACK = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

endpackage

// File: rtl/cache_addr_gen.sv
// rtl/cache_addr_gen.sv - Builds the writeback and refill word addresses for the current line transfer
module cache_addr_gen #(
    parameter int ADDR_BITS        = 32,
    parameter int TAG_BITS         = 22,
    parameter int WORD_BYTES_WIDTH = 2,
    parameter int LINE_WORDS_WIDTH = 2,
    parameter int LINE_INDEX_WIDTH = 6
) (
    input  logic [TAG_BITS-1:0]         victim_tag,
    input  logic [TAG_BITS-1:0]         req_tag,
    input  logic [LINE_INDEX_WIDTH-1:0] index,
    input  logic [LINE_WORDS_WIDTH-1:0] wcnt,
    output logic [ADDR_BITS-1:0]        back_addr,
    output logic [ADDR_BITS-1:0]        fill_addr
);

    assign back_addr = {victim_tag, index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};
    assign fill_addr = {req_tag,    index, wcnt, {WORD_BYTES_WIDTH{1'b0}}};

endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - Direct-mapped cache miss/writeback FSM; CACHE_CTRL_STAT_EN adds hit/miss counters
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int WORD_BITS        = DEF_WORD_BITS,
    parameter int ADDR_BITS        = DEF_ADDR_BITS,
    parameter int TAG_BITS         = DEF_TAG_BITS,
    parameter int WORD_BYTES_WIDTH = DEF_WORD_BYTES_WIDTH,
    parameter int LINE_WORDS_WIDTH = DEF_LINE_WORDS_WIDTH,
    parameter int LINE_INDEX_WIDTH = DEF_LINE_INDEX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_wen,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_wdata,
    output logic [WORD_BITS-1:0] cpu_rdata,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    input  logic                 mem_ack
`ifdef CACHE_CTRL_STAT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int IDX_LO = WORD_BYTES_WIDTH + LINE_WORDS_WIDTH;
    localparam int TAG_LO = IDX_LO + LINE_INDEX_WIDTH;

    logic [1:0]                  state, state_next;
    logic [LINE_WORDS_WIDTH-1:0] wcnt, wcnt_next;
    logic [ADDR_BITS-1:0]        back_addr, fill_addr;
    logic                        idle_hit, idle_miss, last_word;

    assign idle_hit  = (state == ST_IDLE) && cpu_req && cache_hit;
    assign idle_miss = (state == ST_IDLE) && cpu_req && !cache_hit;
    assign last_word = &wcnt;
    assign cpu_rdata = cache_dout;

    cache_addr_gen #(
        .ADDR_BITS        (ADDR_BITS),
        .TAG_BITS         (TAG_BITS),
        .WORD_BYTES_WIDTH (WORD_BYTES_WIDTH),
        .LINE_WORDS_WIDTH (LINE_WORDS_WIDTH),
        .LINE_INDEX_WIDTH (LINE_INDEX_WIDTH)
    ) u_addr_gen (
        .victim_tag (cache_tag),
        .req_tag    (cpu_addr[ADDR_BITS-1:TAG_LO]),
        .index      (cpu_addr[TAG_LO-1:IDX_LO]),
        .wcnt       (wcnt),
        .back_addr  (back_addr),
        .fill_addr  (fill_addr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wcnt_next     = wcnt;
        cpu_stall     = 1'b0;
        cache_addr    = cpu_addr;
        cache_store   = 1'b0;
        cache_edit    = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = cpu_wdata;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_wdata     = cache_dout;
        case (state)
            ST_IDLE: begin
                cpu_stall  = idle_miss;
                cache_edit = idle_hit && cpu_wen;
                if (idle_miss) begin
                    wcnt_next  = '0;
                    state_next = (cache_valid && cache_dirty) ? ST_BACK : ST_FILL;
                end
            end
            ST_BACK: begin
                cpu_stall  = 1'b1;
                cache_addr = back_addr;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                if (mem_ack) begin
                    // wcnt wraps back to 0 after the last word, ready for FILL
                    wcnt_next = wcnt + 1'b1;
                    if (last_word) state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                cpu_stall  = 1'b1;
                cache_addr = fill_addr;
                mem_cs     = 1'b1;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_edit  = 1'b1;
                    cache_din   = mem_rdata;
                    wcnt_next   = wcnt + 1'b1;
                    if (last_word) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        mem_addr = cache_addr;
    end

`ifdef CACHE_CTRL_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (idle_hit)  hit_cnt  <= hit_cnt + 32'd1;
            if (idle_miss) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - Randomized bench for cache_ctrl with array, memory and architectural reference models
`timescale 1ns/1ps
module tb_cache_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_wen = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
    logic        cpu_stall;
    logic [31:0] cache_addr, cache_din, cache_dout;
    logic        cache_store, cache_edit, cache_invalid, cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
`ifdef CACHE_CTRL_STAT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .cache_addr(cache_addr), .cache_store(cache_store), .cache_edit(cache_edit),
        .cache_invalid(cache_invalid), .cache_din(cache_din), .cache_hit(cache_hit),
        .cache_valid(cache_valid), .cache_dirty(cache_dirty), .cache_tag(cache_tag),
        .cache_dout(cache_dout),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STAT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Storage array: 64 lines x 4 words; valid bits clear on reset
    logic [21:0] arr_tag   [64];
    logic        arr_valid [64];
    logic        arr_dirty [64];
    logic [31:0] arr_data  [64][4];

    assign cache_tag   = arr_tag[cpu_addr[9:4]];
    assign cache_valid = arr_valid[cpu_addr[9:4]];
    assign cache_dirty = arr_dirty[cpu_addr[9:4]];
    assign cache_hit   = arr_valid[cache_addr[9:4]] && (arr_tag[cache_addr[9:4]] == cache_addr[31:10]);
    assign cache_dout  = arr_data[cache_addr[9:4]][cache_addr[3:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                arr_valid[i] <= 1'b0;
                arr_dirty[i] <= 1'b0;
                arr_tag[i]   <= '0;
            end
        end else if (cache_edit) begin
            arr_data[cache_addr[9:4]][cache_addr[3:2]] <= cache_din;
            if (cache_store) begin
                arr_tag[cache_addr[9:4]]   <= cache_addr[31:10];
                arr_valid[cache_addr[9:4]] <= 1'b1;
                arr_dirty[cache_addr[9:4]] <= 1'b0;
            end else begin
                arr_dirty[cache_addr[9:4]] <= 1'b1;
            end
        end
    end

    // Main memory with mem_lat cycles per word
    logic [31:0] mem_arr [logic [31:0]];
    txn_t        log_q [$];
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic        spurious = 1'b0;
    logic [31:0] held_addr;
    logic        held_we;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] backing(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
    endfunction

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_cs) begin
            if (mem_cnt == 0) begin
                held_addr = mem_addr;
                held_we   = mem_we;
            end else begin
                n_cmp++;
                if (mem_addr !== held_addr || mem_we !== held_we) begin
                    n_fail++;
                    $display("FAIL mem_stable: addr %h we %b, held %h we %b", mem_addr, mem_we, held_addr, held_we);
                end
            end
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ack = 1'b1;
                mem_cnt = 0;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    log_q.push_back('{1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = backing(mem_addr);
                    log_q.push_back('{1'b0, mem_addr, mem_rdata});
                end
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack   = spurious;
            mem_rdata = $urandom;
            mem_cnt   = 0;
        end
    end

    // Architectural reference: what each address holds from the CPU's view, plus line residency
    logic [31:0] ref_mem [logic [31:0]];
    logic [21:0] rc_tag   [64];
    bit          rc_valid [64];
    bit          rc_dirty [64];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : backing(a);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < 64; i++) rc_valid[i] = 1'b0;
        ref_mem = mem_arr;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
    endtask

    task automatic do_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         output int cycles, output logic [31:0] rdata, output bit timeout);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        #1;
        cycles = 0;
        while (cpu_stall && cycles < 300) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        rdata   = cpu_rdata;
        timeout = cpu_stall;
    endtask

    task automatic check_op(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input string name);
        logic [31:0] wa;
        logic [5:0]  idx;
        logic [21:0] tag;
        bit          hit, wb, timeout;
        txn_t        exp_q [$];
        int          cycles, exp_cycles;
        logic [31:0] rdata, exp_rdata, a;
        wa  = {addr[31:2], 2'b00};
        idx = addr[9:4];
        tag = addr[31:10];
        hit = rc_valid[idx] && (rc_tag[idx] == tag);
        wb  = !hit && rc_valid[idx] && rc_dirty[idx];
        if (wb)
            for (int w = 0; w < 4; w++) begin
                a = {rc_tag[idx], idx, 2'(w), 2'b00};
                exp_q.push_back('{1'b1, a, ref_rd(a)});
            end
        if (!hit)
            for (int w = 0; w < 4; w++) begin
                a = {tag, idx, 2'(w), 2'b00};
                exp_q.push_back('{1'b0, a, 32'h0});
            end
        exp_cycles = hit ? 0 : exp_q.size() * lat + 1;
        exp_rdata  = ref_rd(wa);
        mem_lat = lat;
        log_q.delete();
        do_op(wen, addr, wdata, cycles, rdata, timeout);

        n_cmp++;
        if (timeout) begin
            n_fail++;
            $display("FAIL %s timeout: stall still %b after %0d cycles", name, cpu_stall, cycles);
        end
        n_cmp++;
        if (cycles != exp_cycles) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, cycles, exp_cycles);
        end
        n_cmp++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s mem_txns: got %0d want %0d", name, log_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr ||
                    (exp_q[i].we && log_q[i].data !== exp_q[i].data)) begin
                    n_fail++;
                    $display("FAIL %s txn%0d: got we=%b %h %h want we=%b %h %h", name, i,
                             log_q[i].we, log_q[i].addr, log_q[i].data,
                             exp_q[i].we, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        if (!wen) begin
            n_cmp++;
            if (rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL %s rdata @%h: got %h want %h", name, addr, rdata, exp_rdata);
            end
        end
        if (!hit) begin
            rc_tag[idx]   = tag;
            rc_valid[idx] = 1'b1;
            rc_dirty[idx] = 1'b0;
        end
        if (wen) begin
            ref_mem[wa]   = wdata;
            rc_dirty[idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_1000;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_cs, mem_we, cache_store, cache_edit, cache_invalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got cs/we/st/ed/inv=%b want 00000",
                     {mem_cs, mem_we, cache_store, cache_edit, cache_invalid});
        end
`ifdef CACHE_CTRL_STAT_EN
        n_cmp++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
`endif
        cpu_req = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0 || mem_cs !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got stall=%b cs=%b want 0 0", cpu_stall, mem_cs);
        end
        ref_reset();
    endtask

    task automatic test_fill();
        check_op(1'b0, 32'h0000_1000, 32'h0, 1, "fill_empty");
    endtask

    task automatic test_store_hit();
        @(negedge clk);
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h0000_1004; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (cache_edit !== 1'b1 || cache_store !== 1'b0 || cache_din !== 32'hDEAD_BEEF ||
            mem_cs !== 1'b0 || cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL store_hit: got edit=%b store=%b din=%h cs=%b stall=%b want 1 0 deadbeef 0 0",
                     cache_edit, cache_store, cache_din, mem_cs, cpu_stall);
        end
        idle_cycle();
        n_cmp++;
        if (cache_edit !== 1'b0) begin
            n_fail++;
            $display("FAIL store_hit_pulse: got edit=%b want 0", cache_edit);
        end
        ref_mem[32'h0000_1004] = 32'hDEAD_BEEF;
        rc_dirty[0] = 1'b1;
    endtask

    task automatic test_writeback();
        check_op(1'b0, 32'h0040_1000, 32'h0, 1, "dirty_evict");
        n_cmp++;
        if (backing(32'h0000_1004) !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wb_word1: got %h want deadbeef", backing(32'h0000_1004));
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        cpu_req = 1'b0;
        spurious = 1'b1;
        log_q.delete();
        repeat (2) @(negedge clk);
        spurious = 1'b0;
        #1;
        n_cmp++;
        if (mem_cs !== 1'b0 || log_q.size() != 0) begin
            n_fail++;
            $display("FAIL spurious_ack: got cs=%b txns=%0d want 0 0", mem_cs, log_q.size());
        end
        check_op(1'b0, 32'h0040_1004, 32'h0, 3, "hit_after_spurious");
        check_op(1'b1, 32'h0080_1008, 32'h0BAD_F00D, 3, "lat3_clean_miss");
        check_op(1'b0, 32'h0000_100C, 32'h0, 3, "lat3_dirty_miss");
        idle_cycle();
    endtask

    task automatic test_reset_mid_fill();
        int n;
        mem_lat = 2;
        log_q.delete();
        @(negedge clk);
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h00C0_1004;
        n = 0;
        while (log_q.size() < 1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (log_q.size() < 1) begin
            n_fail++;
            $display("FAIL midfill_first_ack: got %0d txns want 1", log_q.size());
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_cs !== 1'b0 || mem_we !== 1'b0 || cache_edit !== 1'b0 || cache_addr !== cpu_addr) begin
            n_fail++;
            $display("FAIL midfill_reset: got cs=%b we=%b edit=%b addr=%h want 0 0 0 %h",
                     mem_cs, mem_we, cache_edit, cache_addr, cpu_addr);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        rst = 1'b1;
        ref_reset();
        check_op(1'b0, 32'h00C0_1004, 32'h0, 2, "rerequest_after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++)
            check_op(1'(i % 2), {22'h000300, 6'd0, 2'(i / 2), 2'b00}, $urandom, 1, "back_to_back");
        idle_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 80; i++) begin
            a = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            check_op(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 3), "random");
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

`ifdef CACHE_CTRL_STAT_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ref_reset();
        check_op(1'b0, 32'h0100_2000, 32'h0, 1, "stat_miss");
        check_op(1'b0, 32'h0100_2004, 32'h0, 1, "stat_hit1");
        check_op(1'b1, 32'h0100_2008, 32'h1111_2222, 1, "stat_hit2");
        idle_cycle();
        n_cmp++;
        if (miss_cnt !== 32'd1 || hit_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL stats: got hit=%0d miss=%0d want 3 1", hit_cnt, miss_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_store_hit();
        test_writeback();
        test_latency();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
`ifdef CACHE_CTRL_STAT_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
